// File: rtl/stage_fetch_queue_pkg.sv
// Fetch front-end shared constants: instruction width, default reset PC and PC stride.
// No logic, so no latency or backpressure of its own.
package stage_fetch_queue_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam int          PC_INC           = 4;

    typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/stage_fetch_queue_fifo.sv
// Synchronous FIFO with flush, wrap-around pointers plus occupancy count; head is registered, 1-cycle write-to-read.
// A push is taken when not full or when a pop happens in the same cycle; flush beats both.
module stage_fetch_queue_fifo
    import stage_fetch_queue_pkg::*;
#(
    parameter int WIDTH = INST_W + 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic                   o_vld,
    output logic [WIDTH-1:0]       o_dat,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_vld   = (r_count != '0);
    assign o_dat   = o_vld ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/stage_fetch_queue.sv
// In-order instruction fetch with a DEPTH-entry queue and redirect flush; response to inst_valid is 1 cycle.
// Requests are credit-limited (queued + in flight < DEPTH); FETCH_ALIGN_CHECK_EN enables misaligned-redirect fault.
module stage_fetch_queue
    import stage_fetch_queue_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              DEPTH        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-3:0]   mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic              fetch_fault
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam int              CW1        = CW + 1;
    localparam int              QW         = INST_W + XLEN;
    localparam logic [CW:0]     CREDIT_MAX = CW1'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(PC_INC);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [XLEN-1:0] w_redir_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_rsp_cnt;
    logic            w_fault;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_q_vld;
    logic [QW-1:0]   w_q_dat;
    inst_t           w_head_inst;

    assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_rsp_cnt  = CW'(mem_rsp_valid);

    // Queued plus in-flight words never exceed DEPTH, so every response has a slot waiting for it.
    assign mem_req_valid = reset
                        && (({1'b0, w_count} + {1'b0, r_outstanding}) < CREDIT_MAX)
                        && !redirect_valid && !w_fault;
    assign mem_req_addr  = r_pc[XLEN-1:2];
    assign w_issue       = mem_req_valid && mem_req_ready;

    assign w_push = mem_rsp_valid && !redirect_valid && (r_drop == '0);
    assign w_pop  = w_q_vld && inst_ready && !redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_VECTOR;
            r_rsp_pc      <= RESET_VECTOR;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old path, including earlier pending drops.
            r_pc          <= w_redir_pc;
            r_rsp_pc      <= w_redir_pc;
            r_outstanding <= r_outstanding - w_rsp_cnt;
            r_drop        <= r_outstanding - w_rsp_cnt;
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (mem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + PC_STEP;
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - w_rsp_cnt;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fault <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign w_fault = r_fault;
`else
    logic w_unused_lsb;

    assign w_unused_lsb = ^redirect_pc[1:0];
    assign w_fault      = 1'b0;
`endif

    assign fetch_fault = w_fault;

    stage_fetch_queue_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_push_dat ({mem_rsp_data, r_rsp_pc}),
        .i_pop      (w_pop),
        .o_vld      (w_q_vld),
        .o_dat      (w_q_dat),
        .o_count    (w_count)
    );

    assign w_head_inst = w_q_dat[QW-1:XLEN];
    assign inst_valid  = w_q_vld;
    assign inst_data   = w_head_inst;
    assign inst_pc     = w_q_dat[XLEN-1:0];

endmodule

// File: tb/tb_stage_fetch_queue.sv
// Bench for stage_fetch_queue: randomized memory/decode behaviour checked against a queue-based model.
// The model tracks fetch streams by redirect epoch; stale responses must never reach the output.
module tb_stage_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'hBFC0_0000;
    localparam logic [31:0] DKEY  = 32'h5A5A_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [29:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    typedef struct {
        logic [31:0] pc;
        logic [29:0] addr;
        int          epoch;
        int          due;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] iq[$];
    logic [31:0] exp_pc;
    logic        fault_m;
    logic        rst_req;
    int          epoch, cyc, lat, ir_mode, dut_issues;
    bit          rdy_rand, rsp_gap;
    int          nchk, npass, nfail;

    always #5 clk = ~clk;

    stage_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        iq.delete();
        exp_pc  = RV;
        fault_m = 1'b0;
        epoch++;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        reset          = rst_req;
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        mem_req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        case (ir_mode)
            0:       inst_ready = 1'b0;
            1:       inst_ready = 1'b1;
            default: inst_ready = 1'($urandom_range(0, 1));
        endcase
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        if (reset && mq.size() != 0 && mq[0].due <= cyc && !(rsp_gap && $urandom_range(0, 2) == 0)) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {mq[0].addr, 2'b00} ^ DKEY;
        end
    endtask

    task automatic end_cycle();
        logic        ev, issue, pop, rsp, rv;
        logic [31:0] rpc;
        ent_t        e, h;
        #1;
        ev = reset && (iq.size() + mq.size() < DEPTH) && !redirect_valid && !fault_m;
        chk("req_vld", 32'(mem_req_valid), 32'(ev));
        if (ev) chk("req_addr", 32'(mem_req_addr), 32'(exp_pc[31:2]));
        chk("inst_vld", 32'(inst_valid), 32'(iq.size() != 0));
        if (iq.size() != 0) begin
            chk("inst_pc", inst_pc, iq[0]);
            chk("inst_dat", inst_data, iq[0] ^ DKEY);
        end
        chk("fault", 32'(fetch_fault), 32'(fault_m));
        issue = ev && mem_req_ready;
        pop   = (iq.size() != 0) && inst_ready && !redirect_valid;
        rsp   = mem_rsp_valid;
        rv    = redirect_valid;
        rpc   = redirect_pc;
        if (mem_req_valid && mem_req_ready) dut_issues++;
        e = '{pc: exp_pc, addr: mem_req_addr, epoch: epoch, due: 0};
        @(posedge clk);
        cyc++;
        if (!reset) begin
            model_reset();
        end else if (rv) begin
            if (rsp) void'(mq.pop_front());
            iq.delete();
            epoch++;
            exp_pc = {rpc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
            fault_m = (rpc[1:0] != 2'b00);
`endif
        end else begin
            if (pop) void'(iq.pop_front());
            if (rsp) begin
                h = mq.pop_front();
                if (h.epoch == epoch) iq.push_back(h.pc);
            end
            if (issue) begin
                e.due = cyc + lat - 1;
                mq.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic redirect_cycle(input logic [31:0] pc);
        begin_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        end_cycle();
    endtask

    task automatic wait_req(input string tag, input logic [31:0] want_addr);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            begin_cycle();
            #1;
            if (mem_req_valid) begin
                chk(tag, 32'(mem_req_addr), want_addr);
                seen = 1;
            end
            end_cycle();
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found, seen, prev_stall;
        logic [29:0] prev_addr;
        nchk = 0; npass = 0; nfail = 0;
        reset = 1'b0; rst_req = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
        lat = 1; rdy_rand = 0; rsp_gap = 0; ir_mode = 1; cyc = 0; epoch = 0; dut_issues = 0;
        model_reset();

        // Reset state
        run(2);
        begin_cycle();
        #1;
        chk("rst_addr", 32'(mem_req_addr), 32'h2FF0_0000);
        chk("rst_req_vld", 32'(mem_req_valid), 32'd0);
        chk("rst_inst_dat", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        end_cycle();

        // 1: streaming from the reset vector with a 1-cycle memory
        rst_req = 1'b1;
        begin_cycle();
        #1;
        chk("p1_first_vld", 32'(mem_req_valid), 32'd1);
        chk("p1_first_addr", 32'(mem_req_addr), 32'h2FF0_0000);
        end_cycle();
        wait_req("p1_second_addr", 32'h2FF0_0001);
        run(20);

        // 2: decode stalled, credit limit, one pop frees one request
        ir_mode = 0;
        redirect_cycle(32'h0000_4000);
        dut_issues = 0;
        run(12);
        chk("p2_issued", 32'(dut_issues), 32'd4);
        #1;
        chk("p2_stalled", 32'(mem_req_valid), 32'd0);
        ir_mode = 1;
        run(1);
        ir_mode = 0;
        dut_issues = 0;
        run(8);
        chk("p2_one_more", 32'(dut_issues), 32'd1);

        // 3: redirect with three fetches in flight
        lat = 3; ir_mode = 1;
        run(10);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            begin_cycle();
            if (mq.size() == 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_1000;
                found = 1;
            end
            end_cycle();
        end
        chk("p3_found", 32'(found), 32'd1);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            begin_cycle();
            #1;
            if (inst_valid) begin
                chk("p3_first_pc", inst_pc, 32'h0000_1000);
                seen = 1;
            end
            end_cycle();
        end
        chk("p3_seen", 32'(seen), 32'd1);

        // 4: redirect coinciding with a response and a pop
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            begin_cycle();
            if (mem_rsp_valid && iq.size() != 0 && mq.size() >= 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_3000;
                found = 1;
            end
            end_cycle();
        end
        chk("p4_found", 32'(found), 32'd1);
        begin_cycle();
        #1;
        chk("p4_empty", 32'(inst_valid), 32'd0);
        end_cycle();
        run(10);

        // 5: random stalls, 3-cycle memory, random redirects, PC wrap
        rdy_rand = 1; rsp_gap = 1; ir_mode = 2;
        redirect_cycle(32'hFFFF_FFF8);
        prev_stall = 0; prev_addr = '0;
        for (int i = 0; i < 300; i++) begin
            begin_cycle();
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom & 32'hFFFF_FFFC;
            end
            #1;
            if (prev_stall) chk("p5_addr_stable", 32'(mem_req_addr), 32'(prev_addr));
            prev_stall = mem_req_valid && !mem_req_ready && !redirect_valid;
            prev_addr  = mem_req_addr;
            end_cycle();
        end

        // 6: misaligned redirect
        rdy_rand = 0; rsp_gap = 0; ir_mode = 1; lat = 1;
        run(5);
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_cycle(32'h0000_1002);
        dut_issues = 0;
        run(10);
        #1;
        chk("p6_fault", 32'(fetch_fault), 32'd1);
        chk("p6_no_req", 32'(dut_issues), 32'd0);
        redirect_cycle(32'h0000_2000);
        wait_req("p6_resume_addr", 32'h0000_0800);
        chk("p6_fault_clr", 32'(fetch_fault), 32'd0);
`else
        redirect_cycle(32'h0000_1002);
        wait_req("p6_align_addr", 32'h0000_0400);
`endif
        run(10);

        // Asynchronous reset in the middle of traffic
        ir_mode = 2; lat = 3;
        run(10);
        begin_cycle();
        #2;
        rst_req = 1'b0;
        reset   = 1'b0;
        model_reset();
        #1;
        chk("arst_req_vld", 32'(mem_req_valid), 32'd0);
        chk("arst_inst_vld", 32'(inst_valid), 32'd0);
        chk("arst_addr", 32'(mem_req_addr), 32'h2FF0_0000);
        chk("arst_inst_pc", inst_pc, 32'd0);
        end_cycle();
        run(2);
        rst_req = 1'b1;
        run(20);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
